// File: rtl/grn_sweep_if.sv
// rtl/grn_sweep_if.sv - grn launch/ack and per-configuration result bundle for grn_sweep
// res_timeout exists only when GRN_SWEEP_TIMEOUT_EN is defined.
interface grn_sweep_if #(
    parameter int SIZE  = 69,
    parameter int CNT_W = 32
) ();
    logic             grn_start;
    logic [SIZE-1:0]  grn_conf;
    logic             grn_ack;
    logic             grn_done;
    logic [CNT_W-1:0] grn_length;
    logic [CNT_W-1:0] grn_transient;
    logic             res_valid;
    logic             res_ready;
    logic [SIZE-1:0]  res_conf;
    logic [CNT_W-1:0] res_length;
    logic [CNT_W-1:0] res_transient;
`ifdef GRN_SWEEP_TIMEOUT_EN
    logic             res_timeout;
`endif

    modport master (
        output grn_start, grn_conf, grn_ack,
        input  grn_done, grn_length, grn_transient,
        output res_valid, res_conf, res_length, res_transient,
`ifdef GRN_SWEEP_TIMEOUT_EN
        output res_timeout,
`endif
        input  res_ready
    );

    modport slave (
        input  grn_start, grn_conf, grn_ack,
        output grn_done, grn_length, grn_transient,
        input  res_valid, res_conf, res_length, res_transient,
`ifdef GRN_SWEEP_TIMEOUT_EN
        input  res_timeout,
`endif
        output res_ready
    );
endinterface

// File: rtl/grn_sweep.sv
// rtl/grn_sweep.sv - sweeps a range of initial configurations through a grn instance
// Optional WAIT watchdog (parameter TMO, output res_timeout) under GRN_SWEEP_TIMEOUT_EN.
module grn_sweep #(
    parameter int SIZE  = 69,
    parameter int CNT_W = 32
`ifdef GRN_SWEEP_TIMEOUT_EN
    ,
    parameter int TMO   = 1 << 20
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sweep_start,
    input  logic [SIZE-1:0]  sweep_base,
    input  logic [CNT_W-1:0] sweep_count,
    input  logic             sweep_abort,
    output logic             busy,
    output logic             sweep_done,
    output logic [CNT_W-1:0] max_length,
    output logic [CNT_W-1:0] max_transient,
    grn_sweep_if.master      bus
);

    typedef enum logic [2:0] {
        IDLE, LAUNCH, WAIT, ACK, REPORT, NEXT, FINISH
    } state_t;

    state_t           state_q;
    logic [SIZE-1:0]  base_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] index_q;
    logic [CNT_W-1:0] index_d;
    logic [SIZE-1:0]  conf_q;
    logic             start_q;
    logic             ack_q;
    logic             done_q;
    logic             res_valid_q;
    logic [SIZE-1:0]  res_conf_q;
    logic [CNT_W-1:0] res_length_q;
    logic [CNT_W-1:0] res_transient_q;
    logic [CNT_W-1:0] max_length_q;
    logic [CNT_W-1:0] max_transient_q;
`ifdef GRN_SWEEP_TIMEOUT_EN
    logic [31:0]      tmo_q;
    logic             res_timeout_q;
`endif

    assign index_d = index_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            base_q          <= '0;
            count_q         <= '0;
            index_q         <= '0;
            conf_q          <= '0;
            start_q         <= 1'b0;
            ack_q           <= 1'b0;
            done_q          <= 1'b0;
            res_valid_q     <= 1'b0;
            res_conf_q      <= '0;
            res_length_q    <= '0;
            res_transient_q <= '0;
            max_length_q    <= '0;
            max_transient_q <= '0;
`ifdef GRN_SWEEP_TIMEOUT_EN
            tmo_q           <= '0;
            res_timeout_q   <= 1'b0;
`endif
        end else begin
            // Single-cycle strobes fall back to 0 unless a transition re-arms them.
            start_q <= 1'b0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sweep_start) begin
                        base_q          <= sweep_base;
                        count_q         <= sweep_count;
                        index_q         <= '0;
                        max_length_q    <= '0;
                        max_transient_q <= '0;
                        if (sweep_count == '0) begin
                            state_q <= FINISH;
                        end else begin
                            conf_q  <= sweep_base;
                            start_q <= 1'b1;
                            state_q <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
`ifdef GRN_SWEEP_TIMEOUT_EN
                    tmo_q   <= '0;
`endif
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (bus.grn_done) begin
                        res_conf_q      <= conf_q;
                        res_length_q    <= bus.grn_length;
                        res_transient_q <= bus.grn_transient;
                        if (bus.grn_length > max_length_q)
                            max_length_q <= bus.grn_length;
                        if (bus.grn_transient > max_transient_q)
                            max_transient_q <= bus.grn_transient;
                        ack_q   <= 1'b1;
                        state_q <= ACK;
`ifdef GRN_SWEEP_TIMEOUT_EN
                        res_timeout_q <= 1'b0;
                    end else if (tmo_q == 32'(TMO - 1)) begin
                        // Timed-out runs report zeros and leave the maxima alone.
                        res_conf_q      <= conf_q;
                        res_length_q    <= '0;
                        res_transient_q <= '0;
                        res_timeout_q   <= 1'b1;
                        ack_q           <= 1'b1;
                        state_q         <= ACK;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
`endif
                    end
                end
                ACK: begin
                    // Hold until the grn has seen the ack and dropped done.
                    if (!ack_q && !bus.grn_done) begin
                        res_valid_q <= 1'b1;
                        state_q     <= REPORT;
                    end
                end
                REPORT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= NEXT;
                    end
                end
                NEXT: begin
                    index_q <= index_d;
                    if (index_d == count_q || sweep_abort) begin
                        state_q <= FINISH;
                    end else begin
                        conf_q  <= base_q + SIZE'(index_d);
                        start_q <= 1'b1;
                        state_q <= LAUNCH;
                    end
                end
                FINISH: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy              = (state_q != IDLE);
    assign sweep_done        = done_q;
    assign max_length        = max_length_q;
    assign max_transient     = max_transient_q;
    assign bus.grn_start     = start_q;
    assign bus.grn_conf      = conf_q;
    assign bus.grn_ack       = ack_q;
    assign bus.res_valid     = res_valid_q;
    assign bus.res_conf      = res_conf_q;
    assign bus.res_length    = res_length_q;
    assign bus.res_transient = res_transient_q;
`ifdef GRN_SWEEP_TIMEOUT_EN
    assign bus.res_timeout   = res_timeout_q;
`endif

endmodule

// File: doc/grn_sweep.md
GRN_SWEEP -- requirements
Module: grn_sweep

Interface
REQ-001 SHALL have parameter SIZE, default 69, the network state width matching the attached grn instance.
REQ-002 SHALL have parameter CNT_W, default 32, the width of the sweep counter and the length/transient values.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-005 sweep_start  input  1  one-cycle pulse that starts a sweep; sampled only in IDLE.
REQ-006 sweep_base  input  SIZE  first initial configuration; captured on sweep_start.
REQ-007 sweep_count  input  CNT_W  number of configurations to run; captured on sweep_start.
REQ-008 sweep_abort  input  1  level; ends the sweep at the next safe point.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 sweep_done  output  1  one-cycle pulse on the FINISH-to-IDLE transition.
REQ-011 grn_start  output  1  drives grn start_in.
REQ-012 grn_conf  output  SIZE  drives grn conf_in.
REQ-013 grn_ack  output  1  drives grn done_in.
REQ-014 grn_done  input  1  from grn done_out.
REQ-015 grn_length, grn_transient  input  CNT_W each  from grn length_out and transient_out.
REQ-016 res_valid/res_ready  output/input  1 each  per-configuration result handshake.
REQ-017 res_conf, res_length, res_transient  output  SIZE/CNT_W/CNT_W  result payload.
REQ-018 max_length, max_transient  output  CNT_W each  running maxima over the current sweep.

Function
REQ-019 FSM states SHALL be IDLE, LAUNCH, WAIT, ACK, REPORT, NEXT and FINISH.
- IDLE: on sweep_start with sweep_count!=0, SHALL capture base and count, clear the index and both maxima, and go to LAUNCH.
- IDLE: on sweep_start with sweep_count==0, SHALL go directly to FINISH.
REQ-020 LAUNCH: grn_conf = base + index (modulo 2^SIZE, wrapping); SHALL assert grn_start for exactly one cycle, then go to WAIT.
REQ-021 grn_conf SHALL be held stable from LAUNCH until the next LAUNCH.
REQ-022 WAIT: on grn_done=1, SHALL capture grn_length/grn_transient into the result registers, update the maxima (strict greater-than), and go to ACK.
REQ-023 ACK: SHALL assert grn_ack for one cycle, then stay in ACK until grn_done=0, then go to REPORT.
REQ-024 REPORT: SHALL hold res_valid=1 with a stable payload until res_ready=1; the transfer occurs in the cycle where both are high, then the FSM goes to NEXT.
REQ-025 res_ready already high on REPORT entry SHALL complete the transfer in that first REPORT cycle.
REQ-026 NEXT: index+1; if the new index equals count, or sweep_abort=1, SHALL go to FINISH; otherwise SHALL go to LAUNCH.
REQ-027 FINISH: SHALL pulse sweep_done and return to IDLE; the maxima SHALL hold until the next sweep_start.
REQ-028 sweep_abort SHALL be honoured only in NEXT and IDLE-independent, so no grn run is ever orphaned.
REQ-029 sweep_start while busy SHALL be ignored.
REQ-030 Minimum latency from LAUNCH to REPORT SHALL be grn latency + 3 cycles.

Reset
REQ-031 rst=0 SHALL asynchronously force IDLE and set every output to 0: busy, sweep_done, grn_start, grn_ack, grn_conf, res_*, and max_*.
REQ-032 Reset mid-sweep SHALL discard all progress; the grn instance is reset by the same rst net.

Configuration
REQ-033 Macro GRN_SWEEP_TIMEOUT_EN SHALL control a WAIT-state watchdog.
- Defined: adds parameter TMO, default 2^20 cycles, and output res_timeout (1 bit).
- Defined: in WAIT, after TMO cycles without grn_done, SHALL go to ACK with res_length=0, res_transient=0 and res_timeout=1; res_timeout=0 for normal completion.
- Defined: a timed-out run SHALL NOT update the maxima.
- Undefined: WAIT SHALL wait indefinitely, and neither the port nor the parameter SHALL exist.

Verification
REQ-034 sweep_base=5, sweep_count=3, grn model returning length=4/transient=7 after 10 cycles, res_ready=1 -> three results with res_conf 5, 6, 7, then a sweep_done pulse; max_length=4, max_transient=7.
REQ-035 sweep_count=0 -> sweep_done pulses 2 cycles after sweep_start; grn_start never asserts.
REQ-036 sweep_base=all-ones, sweep_count=2 -> res_conf all-ones, then 0 (wrap).
REQ-037 res_ready held 0 for 20 cycles in REPORT -> res_valid stays 1 with an unchanged payload, and no grn_start is issued.
REQ-038 sweep_abort raised during the second of 5 runs -> the second result completes, then FINISH; exactly 2 results are delivered.
REQ-039 With GRN_SWEEP_TIMEOUT_EN and TMO=16, grn_done never asserted -> after 16 WAIT cycles: result with res_timeout=1 and length 0; maxima unchanged.
